// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame size, FSM encoding and
// the helpers that assemble a frame from a byte and its line configuration.
package uart_pkg;

  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } txState_e;

  function automatic logic calcParity(input logic [7:0] data,
                                      input logic       eight,
                                      input logic       odd);
    return (eight ? ^data : ^data[6:0]) ^ odd;
  endfunction

  // Slots not used by the chosen configuration stay at mark so every frame is 11 bit-times.
  function automatic logic [FRAME_BITS-1:0] buildFrame(input logic [7:0] data,
                                                       input logic       eight,
                                                       input logic       pen,
                                                       input logic       odd);
    logic [FRAME_BITS-1:0] frame;
    logic                  par;
    par        = calcParity(data, eight, odd);
    frame      = '1;
    frame[0]   = 1'b0;
    frame[7:1] = data[6:0];
    if (eight) begin
      frame[8] = data[7];
      frame[9] = pen ? par : 1'b1;
    end else begin
      frame[8] = pen ? par : 1'b1;
    end
    return frame;
  endfunction

endpackage

// File: rtl/bit_time_gen.sv
// Bit-time generator: pulses btu once every div cycles while enabled.
// A divisor of 0 or 1 yields a pulse on every enabled cycle.
module bit_time_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             btu
);

  logic [DIV_W-1:0] count_q, count_d;

  always_comb begin
    btu     = en && ((div <= DIV_W'(1)) || (count_q == div - DIV_W'(1)));
    count_d = count_q;
    if (!en || btu) begin
      count_d = '0;
    end else begin
      count_d = count_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmit controller: accepts a byte and line configuration, then
// serialises start/data/parity/stop on tx and pulses tx_done at the end.
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int DIV_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [7:0]       data_in,
  input  logic             eight,
  input  logic             pen,
  input  logic             ohel,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tx,
  output logic             tx_rdy,
  output logic             tx_done,
  output logic             busy
);

  txState_e              state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [3:0]            bitCnt_q, bitCnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  btu;
  logic                  sending;

  assign sending = (state_q == SEND);

  bit_time_gen #(
    .DIV_W(DIV_W)
  ) u_bitTimeGen (
    .clk  (clk),
    .reset(reset),
    .en   (sending),
    .div  (div_q),
    .btu  (btu)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    div_d    = div_q;
    tx       = 1'b1;
    tx_rdy   = 1'b0;
    tx_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_rdy = 1'b1;
        if (load) begin
          shift_d  = buildFrame(data_in, eight, pen, ohel);
          div_d    = baud_div;
          bitCnt_d = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        tx = shift_q[0];
        if (btu) begin
          shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
          // The last bit wraps the counter to 0 so it never reaches FRAME_BITS.
          if (bitCnt_q == 4'(FRAME_BITS - 1)) begin
            bitCnt_d = '0;
            state_d  = DONE;
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end
      end
      DONE: begin
        tx_done = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy = ~tx_rdy;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '1;
      bitCnt_q <= '0;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
      div_q    <= div_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Self-checking bench for uart_tx_controller: each accepted load pushes the
// expected frame onto a scoreboard, and a negedge monitor checks it on tx_done.
module tb_uart_tx_controller;

  localparam int DIV_W = 19;

  typedef struct {
    logic [10:0] frame;
    int          div;
    int          loadCycle;
  } sbEntry_t;

  logic             clk;
  logic             reset;
  logic             load;
  logic [7:0]       data_in;
  logic             eight;
  logic             pen;
  logic             ohel;
  logic [DIV_W-1:0] baud_div;
  logic             tx;
  logic             tx_rdy;
  logic             tx_done;
  logic             busy;

  int       checks = 0;
  int       errors = 0;
  int       cycle  = 0;
  sbEntry_t sbQ[$];
  logic     streamQ[$];
  logic     rdyPending = 1'b0;

  uart_tx_controller #(
    .DIV_W(DIV_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .data_in (data_in),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .baud_div(baud_div),
    .tx      (tx),
    .tx_rdy  (tx_rdy),
    .tx_done (tx_done),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Reference frame: parity from an explicit count of ones in the data bits.
  function automatic logic [10:0] expFrame(input logic [7:0] d, input logic e,
                                           input logic p, input logic o);
    int          ones;
    logic        par;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < (e ? 8 : 7); i++) ones += int'(d[i]);
    par = ((ones % 2) == 1) ^ o;
    f   = 11'h7FF;
    f[0] = 1'b0;
    for (int i = 0; i < 7; i++) f[i+1] = d[i];
    if (e) f[8] = d[7];
    if (p) begin
      if (e) f[9] = par;
      else   f[8] = par;
    end
    return f;
  endfunction

  // Monitor: records tx each cycle of a frame, decodes it when tx_done arrives.
  always @(negedge clk) begin
    sbEntry_t    e;
    logic [10:0] got;
    int          bad;
    if (rdyPending) begin
      checkOutput("rdy_after_done", tx_rdy, 1);
      rdyPending = 1'b0;
    end
    if (busy && !tx_done) begin
      streamQ.push_back(tx);
    end else if (tx_done) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", tx_done, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("done_cycle", cycle, e.loadCycle + 1 + 11 * e.div);
        checkOutput("frame_len", streamQ.size(), 11 * e.div);
        checkOutput("done_tx_idle", tx, 1);
        if (streamQ.size() == 11 * e.div) begin
          got = '0;
          bad = 0;
          for (int i = 0; i < 11; i++) begin
            got[i] = streamQ[i * e.div];
            for (int j = 1; j < e.div; j++)
              if (streamQ[i * e.div + j] !== got[i]) bad++;
          end
          checkOutput("frame_bits", got, e.frame);
          checkOutput("bit_width", bad, 0);
        end
      end
      rdyPending = 1'b1;
      streamQ.delete();
    end else begin
      streamQ.delete();
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic e, input logic p,
                               input logic o, input int div, output int loadCycle);
    sbEntry_t s;
    int       t;
    t = 0;
    @(negedge clk);
    while (!tx_rdy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!tx_rdy) checkOutput("rdy_timeout", tx_rdy, 1);
    data_in  = d;
    eight    = e;
    pen      = p;
    ohel     = o;
    baud_div = DIV_W'(div);
    load     = 1'b1;
    s.frame     = expFrame(d, e, p, o);
    s.div       = (div == 0) ? 1 : div;
    s.loadCycle = cycle;
    loadCycle   = cycle;
    sbQ.push_back(s);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int t;
    t = 0;
    while (sbQ.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checkOutput(tag, sbQ.size(), 0);
  endtask

  initial begin
    int L;
    int t;
    reset    = 1'b0;
    load     = 1'b1;
    data_in  = 8'hA5;
    eight    = 1'b1;
    pen      = 1'b0;
    ohel     = 1'b0;
    baud_div = DIV_W'(4);

    // Reset held with load asserted must keep the line idle.
    repeat (5) begin
      @(negedge clk);
      checkOutput("rst_tx", tx, 1);
      checkOutput("rst_rdy", tx_rdy, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", tx_done, 0);
    end
    load  = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, 4, L);
    waitDrain("drain_55");
    applyStimulus(8'h03, 1'b1, 1'b1, 1'b0, 3, L);
    applyStimulus(8'h03, 1'b1, 1'b1, 1'b1, 1, L);
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 0, L);
    applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0, 2, L);

    // A load pulse during the DONE cycle must be ignored.
    @(negedge clk);
    t = 0;
    while (!tx_done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("saw_done", tx_done, 1);
    load    = 1'b1;
    data_in = 8'h00;
    @(negedge clk);
    load = 1'b0;
    checkOutput("done_load_ignored", busy, 0);
    @(negedge clk);
    checkOutput("done_load_idle", busy, 0);
    waitDrain("drain_cfg");

    // Mid-frame load and config changes must not disturb the frame in flight.
    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b1, 5, L);
    while (cycle < L + 10) @(negedge clk);
    load     = 1'b1;
    data_in  = 8'h00;
    eight    = 1'b0;
    baud_div = DIV_W'(2);
    @(negedge clk);
    load = 1'b0;
    waitDrain("drain_a5");
    repeat (5) begin
      @(negedge clk);
      checkOutput("no_second_frame", busy, 0);
    end

    // Reset during data bit 3 aborts without a done pulse.
    applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0, 4, L);
    while (cycle < L + 18) @(negedge clk);
    void'(sbQ.pop_back());
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_tx", tx, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", tx_done, 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_no_done", tx_done, 0);
    end
    reset = 1'b1;
    applyStimulus(8'h96, 1'b1, 1'b1, 1'b0, 3, L);
    waitDrain("final_drain");
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
